// File: rtl/uc_seq_pkg.sv
// Shared opcode constants, sequencer state codes and the control-word layout
// for the microcontroller control unit.
package uc_seq_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 3;

  localparam logic [OP_W-1:0] OP_J    = 6'b100000;
  localparam logic [OP_W-1:0] OP_JZ   = 6'b100001;
  localparam logic [OP_W-1:0] OP_JNZ  = 6'b100010;
  localparam logic [OP_W-1:0] OP_HALT = 6'b100011;
  localparam logic [OP_W-1:0] OP_NOP  = 6'b100100;

  localparam logic [ALUOP_W-1:0] ALU_LI = 3'b000;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_TRAP = 2'b10
  } state_e;

  typedef struct packed {
    logic               s_inc;
    logic               s_inm;
    logic               we;
    logic               wez;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  // Safe word: hold PC on its jump target, no register or flag writes.
  localparam ctrl_t CTRL_IDLE = '{s_inc: 1'b0, s_inm: 1'b0, we: 1'b0, wez: 1'b0,
                                  alu_op: ALU_LI};

endpackage

// File: rtl/uc_seq_decode.sv
// Combinational instruction decode: Opcode and zero flag to control word,
// plus HALT / illegal-opcode indications for the sequencer.
module uc_seq_decode
  import uc_seq_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output ctrl_t           ctrl_c,
  output logic            is_halt_c,
  output logic            is_illegal_c
);

  always_comb begin
    ctrl_c       = CTRL_IDLE;
    is_halt_c    = 1'b0;
    is_illegal_c = 1'b0;
    if (!opcode[5]) begin
      // ALU class: LI takes the immediate and leaves the zero flag alone.
      ctrl_c.alu_op = opcode[4:2];
      ctrl_c.s_inc  = 1'b1;
      ctrl_c.we     = 1'b1;
      if (opcode[4:2] == ALU_LI) begin
        ctrl_c.s_inm = 1'b1;
      end else begin
        ctrl_c.wez = 1'b1;
      end
    end else begin
      case (opcode)
        OP_J:    ctrl_c.s_inc = 1'b0;
        OP_JZ:   ctrl_c.s_inc = ~zero;
        OP_JNZ:  ctrl_c.s_inc = zero;
        OP_HALT: is_halt_c    = 1'b1;
        OP_NOP:  ctrl_c.s_inc = 1'b1;
        default: is_illegal_c = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uc_seq.sv
// Control unit for the single-cycle datapath: decode plus a RUN/HALT/TRAP
// sequencer, resume handshake and saturating retired-instruction counter.
module uc_seq
  import uc_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    Opcode,
  input  logic               zero,
  input  logic               resume,
  output logic               s_inc,
  output logic               s_inm,
  output logic               we,
  output logic               wez,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               halted,
  output logic               trap,
  output logic [CNT_W-1:0]   icount
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  ctrl_t            dec_c;
  ctrl_t            ctrl_c;
  logic             is_halt_c;
  logic             is_illegal_c;

  uc_seq_decode u_decode (
    .opcode       (Opcode),
    .zero         (zero),
    .ctrl_c       (dec_c),
    .is_halt_c    (is_halt_c),
    .is_illegal_c (is_illegal_c)
  );

  always_comb begin
    state_d  = state_q;
    icount_d = icount_q;
    ctrl_c   = CTRL_IDLE;
    case (state_q)
      ST_RUN: begin
        ctrl_c = dec_c;
        if (icount_q != '1) begin
          icount_d = icount_q + CNT_W'(1);
        end
        // The trapping instruction must not commit anything.
        if (is_illegal_c) begin
          ctrl_c.s_inc = 1'b0;
          ctrl_c.we    = 1'b0;
          ctrl_c.wez   = 1'b0;
          state_d      = ST_TRAP;
        end else if (is_halt_c) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (resume) begin
          ctrl_c.s_inc = 1'b1;
          state_d      = ST_RUN;
        end
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_RUN;
    endcase
    // Keep the datapath inert but stepping while reset is held.
    if (!reset) begin
      ctrl_c       = CTRL_IDLE;
      ctrl_c.s_inc = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      icount_q <= icount_d;
    end
  end

  assign s_inc  = ctrl_c.s_inc;
  assign s_inm  = ctrl_c.s_inm;
  assign we     = ctrl_c.we;
  assign wez    = ctrl_c.wez;
  assign ALUOp  = ctrl_c.alu_op;
  assign halted = (state_q == ST_HALT);
  assign trap   = (state_q == ST_TRAP);
  assign icount = icount_q;

endmodule

// File: tb/tb_uc_seq.sv
// Scoreboard bench for uc_seq: a 16-bit counter instance for the main scenarios
// and a 4-bit counter instance for saturation and mid-HALT reset.
module tb_uc_seq;

  typedef struct packed {
    logic        s_inc;
    logic        s_inm;
    logic        we;
    logic        wez;
    logic [2:0]  alu;
    logic        halted;
    logic        trap;
    logic [15:0] icount;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  Opcode = 6'b0;
  logic        zero = 1'b0;
  logic        resume = 1'b0;
  logic        s_inc, s_inm, we, wez, halted, trap;
  logic [2:0]  ALUOp;
  logic [15:0] icount;

  logic        reset4 = 1'b0;
  logic [5:0]  op4 = 6'b0;
  logic        s_inc4, s_inm4, we4, wez4, halted4, trap4;
  logic [2:0]  alu4;
  logic [3:0]  icount4;

  int   checks = 0;
  int   failures = 0;
  int   cnt = 0;
  exp_t sb[$];
  exp_t e, o;

  always #5 clk = ~clk;

  uc_seq #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero), .resume(resume),
    .s_inc(s_inc), .s_inm(s_inm), .we(we), .wez(wez), .ALUOp(ALUOp),
    .halted(halted), .trap(trap), .icount(icount)
  );

  uc_seq #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset4), .Opcode(op4), .zero(zero), .resume(resume),
    .s_inc(s_inc4), .s_inm(s_inm4), .we(we4), .wez(wez4), .ALUOp(alu4),
    .halted(halted4), .trap(trap4), .icount(icount4)
  );

  function automatic exp_t mk(input logic [6:0] c, input logic h, input logic t, input int n);
    exp_t r;
    r.s_inc  = c[6];
    r.s_inm  = c[5];
    r.we     = c[4];
    r.wez    = c[3];
    r.alu    = c[2:0];
    r.halted = h;
    r.trap   = t;
    r.icount = 16'(n);
    return r;
  endfunction

  function automatic exp_t obs_main();
    exp_t r;
    r.s_inc = s_inc; r.s_inm = s_inm; r.we = we; r.wez = wez; r.alu = ALUOp;
    r.halted = halted; r.trap = trap; r.icount = icount;
    return r;
  endfunction

  function automatic exp_t obs_sat();
    exp_t r;
    r.s_inc = s_inc4; r.s_inm = s_inm4; r.we = we4; r.wez = wez4; r.alu = alu4;
    r.halted = halted4; r.trap = trap4; r.icount = 16'(icount4);
    return r;
  endfunction

  // Drive one cycle's inputs on the falling edge; outputs are sampled 2 units later.
  task automatic cyc(input logic [5:0] op, input logic z, input logic res, input logic rst);
    @(negedge clk);
    Opcode = op; zero = z; resume = res; reset = rst;
    #2;
  endtask

  task automatic cyc4(input logic [5:0] op, input logic rst);
    @(negedge clk);
    op4 = op; zero = 1'b0; resume = 1'b0; reset4 = rst;
    #2;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(7'b1000000, 1'b0, 1'b0, 0));
      cyc(6'b000000, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front(); o = obs_main(); checks++;
      if (o.s_inc !== e.s_inc || o.we !== e.we || o.wez !== e.wez ||
          o.halted !== e.halted || o.trap !== e.trap || o.icount !== e.icount) begin
        failures++;
        $display("FAIL reset_hold[%0d]: got %h required %h", i, o, e);
      end
    end
    sb.push_back(mk(7'b1110000, 1'b0, 1'b0, 0));
    cyc(6'b000000, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL reset_release_li: got %h required %h", o, e);
    end
    cnt = 1;
  endtask

  task automatic test_alu();
    logic [5:0] ops[4] = '{6'b010100, 6'b011100, 6'b000011, 6'b001001};
    logic [6:0] ctl[4] = '{7'b1011101, 7'b1011111, 7'b1110000, 7'b1011010};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(ctl[i], 1'b0, 1'b0, cnt));
      cyc(ops[i], 1'b0, (i == 2), 1'b1);
      cnt++;
      e = sb.pop_front(); o = obs_main(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL alu_op[%0d]: got %h required %h", i, o, e);
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops[6] = '{6'b100001, 6'b100001, 6'b100010, 6'b100010, 6'b100000, 6'b100100};
    logic       zs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [6:0] ctl[6] = '{7'b0000000, 7'b1000000, 7'b1000000, 7'b0000000, 7'b0000000, 7'b1000000};
    for (int i = 0; i < 6; i++) begin
      sb.push_back(mk(ctl[i], 1'b0, 1'b0, cnt));
      cyc(ops[i], zs[i], 1'b0, 1'b1);
      cnt++;
      e = sb.pop_front(); o = obs_main(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL branch[%0d]: got %h required %h", i, o, e);
      end
    end
  endtask

  task automatic test_halt();
    cyc(6'b100100, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(mk(7'b1000000, 1'b0, 1'b0, cnt));
      cyc(6'b100100, 1'b0, 1'b0, 1'b1);
      cnt++;
      e = sb.pop_front(); o = obs_main(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL halt_lead_nop[%0d]: got %h required %h", i, o, e);
      end
    end
    sb.push_back(mk(7'b0000000, 1'b0, 1'b0, 5));
    for (int i = 0; i < 10; i++) sb.push_back(mk(7'b0000000, 1'b1, 1'b0, 6));
    sb.push_back(mk(7'b1000000, 1'b1, 1'b0, 6));
    sb.push_back(mk(7'b1000000, 1'b0, 1'b0, 6));
    sb.push_back(mk(7'b0000000, 1'b0, 1'b0, 7));
    sb.push_back(mk(7'b0000000, 1'b0, 1'b0, 8));
    sb.push_back(mk(7'b0000000, 1'b1, 1'b0, 9));
    sb.push_back(mk(7'b1000000, 1'b1, 1'b0, 9));
    for (int i = 0; i < 17; i++) begin
      // step 0 halts; 11 resumes; 13..14 jump onto a second HALT; 16 resumes again
      if (i <= 11) cyc(6'b100011, 1'b0, (i == 11), 1'b1);
      else if (i == 12) cyc(6'b100100, 1'b0, 1'b0, 1'b1);
      else if (i == 13) cyc(6'b100000, 1'b0, 1'b0, 1'b1);
      else cyc(6'b100011, 1'b0, (i == 16), 1'b1);
      e = sb.pop_front(); o = obs_main(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL halt_seq[%0d]: got %h required %h", i, o, e);
      end
    end
    cnt = 9;
  endtask

  task automatic test_trap();
    logic [5:0] ops[6] = '{6'b100100, 6'b111111, 6'b000000, 6'b100100, 6'b100011, 6'b010100};
    sb.push_back(mk(7'b1000000, 1'b0, 1'b0, cnt));
    sb.push_back(mk(7'b0000000, 1'b0, 1'b0, cnt + 1));
    for (int i = 0; i < 4; i++) sb.push_back(mk(7'b0000000, 1'b0, 1'b1, cnt + 2));
    for (int i = 0; i < 6; i++) begin
      cyc(ops[i], 1'b0, (i >= 3), 1'b1);
      e = sb.pop_front(); o = obs_main(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL trap_seq[%0d]: got %h required %h", i, o, e);
      end
    end
    sb.push_back(mk(7'b1000000, 1'b0, 1'b0, 0));
    cyc(6'b100100, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); o = obs_main(); checks++;
    if (o.s_inc !== e.s_inc || o.we !== e.we || o.wez !== e.wez ||
        o.halted !== e.halted || o.trap !== e.trap || o.icount !== e.icount) begin
      failures++;
      $display("FAIL trap_reset_clear: got %h required %h", o, e);
    end
    sb.push_back(mk(7'b0000000, 1'b0, 1'b0, 0));
    sb.push_back(mk(7'b0000000, 1'b0, 1'b1, 1));
    for (int i = 0; i < 2; i++) begin
      cyc((i == 0) ? 6'b101000 : 6'b100100, 1'b0, 1'b0, 1'b1);
      e = sb.pop_front(); o = obs_main(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL trap_first_op[%0d]: got %h required %h", i, o, e);
      end
    end
  endtask

  task automatic test_saturate();
    cyc4(6'b000100, 1'b0);
    for (int i = 0; i < 20; i++) begin
      sb.push_back(mk(7'b1011001, 1'b0, 1'b0, (i > 15) ? 15 : i));
      cyc4(6'b000100, 1'b1);
      e = sb.pop_front(); o = obs_sat(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL sat_count[%0d]: got %h required %h", i, o, e);
      end
    end
    sb.push_back(mk(7'b0000000, 1'b0, 1'b0, 15));
    sb.push_back(mk(7'b0000000, 1'b1, 1'b0, 15));
    for (int i = 0; i < 2; i++) begin
      cyc4(6'b100011, 1'b1);
      e = sb.pop_front(); o = obs_sat(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL sat_halt[%0d]: got %h required %h", i, o, e);
      end
    end
    sb.push_back(mk(7'b1000000, 1'b0, 1'b0, 0));
    #1 reset4 = 1'b0;
    #1;
    e = sb.pop_front(); o = obs_sat(); checks++;
    if (o.s_inc !== e.s_inc || o.we !== e.we || o.wez !== e.wez ||
        o.halted !== e.halted || o.trap !== e.trap || o.icount !== e.icount) begin
      failures++;
      $display("FAIL sat_async_reset: got %h required %h", o, e);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_halt();
    test_trap();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
